// File: rtl/ir_control_sequencer.sv
// Hardwired fetch/decode/execute sequencer: one T-state per clock, decoded strobes, multi-cycle MUL/DIV, HALT and illegal trap.
// Optional feature: define IR_SEQ_INSTR_COUNT_EN to add the 32-bit instr_count output.
module ir_control_sequencer #(
    parameter int NUM_REGS      = 16,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    output logic                pc_out,
    output logic                mar_in,
    output logic                inc_pc,
    output logic                read,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                ir_in,
    output logic                y_in,
    output logic                z_in,
    output logic                z_low_out,
    output logic                z_high_out,
    output logic                hi_in,
    output logic                lo_in,
    output logic [NUM_REGS-1:0] gpr_in,
    output logic [NUM_REGS-1:0] gpr_out,
    output logic [3:0]          alu_op,
    output logic                halted,
    output logic                illegal_op,
    output logic [3:0]          state
`ifdef IR_SEQ_INSTR_COUNT_EN
    ,
    output logic [31:0]         instr_count
`endif
);

    localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic [4:0] opcode;
    logic [3:0] ra_field, rb_field, rc_field;
    logic       alu_class, is_muldiv, is_halt, reg_oob, is_illegal;
    logic [3:0] alu_sel;
    logic       ra_en, rb_en, rc_en;
    logic       unused_ir_bits;

    assign opcode         = ir[31:27];
    assign ra_field       = ir[26:23];
    assign rb_field       = ir[22:19];
    assign rc_field       = ir[18:15];
    assign unused_ir_bits = ^ir[14:0];

    always_comb begin
        alu_class = 1'b1;
        is_muldiv = 1'b0;
        alu_sel   = 4'b0000;
        case (opcode)
            5'b00011: alu_sel = 4'b0010;
            5'b00100: alu_sel = 4'b0011;
            5'b01001: alu_sel = 4'b0000;
            5'b01010: alu_sel = 4'b0001;
            5'b01110: begin alu_sel = 4'b0100; is_muldiv = 1'b1; end
            5'b01111: begin alu_sel = 4'b0101; is_muldiv = 1'b1; end
            default:  alu_class = 1'b0;
        endcase
    end

    // Fields are compared at full width so a 4-bit index above NUM_REGS-1 traps instead of aliasing.
    assign is_halt    = (opcode == 5'b11011);
    assign reg_oob    = ({1'b0, ra_field} >= 5'(NUM_REGS)) ||
                        ({1'b0, rb_field} >= 5'(NUM_REGS)) ||
                        ({1'b0, rc_field} >= 5'(NUM_REGS));
    assign is_illegal = !is_halt && (!alu_class || reg_oob);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pc_out     = 1'b0;
        mar_in     = 1'b0;
        inc_pc     = 1'b0;
        read       = 1'b0;
        mdr_in     = 1'b0;
        mdr_out    = 1'b0;
        ir_in      = 1'b0;
        y_in       = 1'b0;
        z_in       = 1'b0;
        z_low_out  = 1'b0;
        z_high_out = 1'b0;
        hi_in      = 1'b0;
        lo_in      = 1'b0;
        alu_op     = 4'b0000;
        halted     = 1'b0;
        illegal_op = 1'b0;
        ra_en      = 1'b0;
        rb_en      = 1'b0;
        rc_en      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (run) state_next = S_T0;
            end
            S_T0: begin
                pc_out     = 1'b1;
                mar_in     = 1'b1;
                inc_pc     = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                read   = 1'b1;
                mdr_in = 1'b1;
                if (mem_ready) state_next = S_T2;
            end
            S_T2: begin
                mdr_out    = 1'b1;
                ir_in      = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                if (is_halt) begin
                    state_next = S_HALT;
                end else if (is_illegal) begin
                    illegal_op = 1'b1;
                    state_next = run ? S_T0 : S_IDLE;
                end else begin
                    rb_en      = 1'b1;
                    y_in       = 1'b1;
                    state_next = S_T4;
                    if (is_muldiv) cnt_next = CW'(MULDIV_CYCLES - 1);
                end
            end
            S_T4: begin
                rc_en  = 1'b1;
                z_in   = 1'b1;
                alu_op = alu_sel;
                if (!is_muldiv || cnt_reg == '0) state_next = S_T5;
                else                             cnt_next   = cnt_reg - CW'(1);
            end
            S_T5: begin
                z_low_out = 1'b1;
                if (is_muldiv) begin
                    lo_in      = 1'b1;
                    state_next = S_T6;
                end else begin
                    ra_en      = 1'b1;
                    state_next = run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                z_high_out = 1'b1;
                hi_in      = 1'b1;
                state_next = run ? S_T0 : S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Each enable is gated to a single state, so gpr_in and gpr_out can never overlap.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_gpr
        assign gpr_out[gi] = !reg_oob && ((rb_en && rb_field == 4'(gi)) ||
                                          (rc_en && rc_field == 4'(gi)));
        assign gpr_in[gi]  = !reg_oob && ra_en && (ra_field == 4'(gi));
    end

    assign state = state_reg;

`ifdef IR_SEQ_INSTR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count <= '0;
        end else if ((state_reg == S_T5 && !is_muldiv) || state_reg == S_T6) begin
            instr_count <= instr_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/ir_control_sequencer.md
Name: ir_control_sequencer

Overview:
- Hardwired control unit that generates the fetch/decode/execute control strobes for the datapath, one microstep (T-state) per clock.
- Reads register fields from the IR and drives one-hot GPR enables, ALU op, memory handshake and HI/LO writeback.
- Generalises the fixed T0–T5 register-ALU sequence: parametrised register count, memory wait-states, multi-cycle MUL/DIV, HALT, illegal-opcode trap.

Parameters:
- NUM_REGS, 16, number of GPRs; width of gpr_in/gpr_out; legal range 2..16.
- MULDIV_CYCLES, 4, cycles z_in is held in T4 for MUL/DIV; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- run  input  1  level; allows instruction start from IDLE and at instruction boundaries
- ir  input  32  IR register contents; opcode [31:27], ra [26:23], rb [22:19], rc [18:15]
- mem_ready  input  1  memory read data valid on m_data_in this cycle
- pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in, y_in, z_in, z_low_out, z_high_out, hi_in, lo_in  output  1 each  datapath strobes
- gpr_in  output  NUM_REGS  one-hot register write enable
- gpr_out  output  NUM_REGS  one-hot register bus drive
- alu_op  output  4  ALU function select
- halted  output  1  high while in HALT
- illegal_op  output  1  one-cycle pulse on an undefined opcode or an out-of-range register field
- state  output  4  current state encoding, for debug

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- State register updates on posedge clk.
- All outputs are a combinational decode of the state register and ir. No output depends on run.
- Every output not listed for a state is 0.
- State encodings: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, HALT=8.
- Reset has priority over all other conditions:
  - Next state IDLE and MULDIV counter cleared, even mid-instruction.
  - All outputs are 0 in IDLE.
- Opcode map (5-bit) -> alu_op:
  - ADD 00011 -> 0010
  - SUB 00100 -> 0011
  - AND 01001 -> 0000
  - OR 01010 -> 0001
  - MUL 01110 -> 0100
  - DIV 01111 -> 0101
  - HALT 11011
  - All other opcodes are illegal.
- An ALU-class instruction (any of the six arithmetic/logic opcodes) whose ra, rb or rc >= NUM_REGS is illegal.
- IDLE: run=1 -> T0; otherwise stay.
- T0: pc_out, mar_in, inc_pc asserted -> T1.
- T1: read, mdr_in held asserted until mem_ready=1 is sampled, then -> T2. No timeout.
- T2: mdr_out, ir_in asserted -> T3. The IR loads at the end of T2.
- T3 (ir is valid from here on):
  - HALT opcode: no strobes -> HALT.
  - Illegal: illegal_op=1, no other strobes -> T0 if run=1, else IDLE.
  - Otherwise: gpr_out[rb], y_in asserted -> T4.
- T4: gpr_out[rc], z_in asserted, alu_op driven.
  - ALU ops: one cycle -> T5.
  - MUL/DIV: held for MULDIV_CYCLES consecutive cycles (counter loads at entry, decrements each cycle), then -> T5.
- T5:
  - ALU ops: z_low_out, gpr_in[ra] asserted; instruction boundary.
  - MUL/DIV: z_low_out, lo_in asserted -> T6.
- T6 (MUL/DIV only): z_high_out, hi_in asserted; instruction boundary.
- Instruction boundary: -> T0 if run=1, else IDLE.
- HALT: halted=1, all strobes 0; exit only via reset.
- One-hot guarantee: gpr_in and gpr_out never have more than one bit set, and are never both non-zero in the same cycle.
- Latency with mem_ready high in the first T1 cycle:
  - ALU instruction: 6 cycles.
  - MUL/DIV: 6+MULDIV_CYCLES cycles.
  - Each extra cycle of mem_ready low adds one cycle.
- A 4-bit ir field wider than needed when NUM_REGS<16 is handled by the illegal check, never by truncation.

Optional Feature:
- Macro IR_SEQ_INSTR_COUNT_EN.
- Defined:
  - Adds output instr_count (32 bits), reset to 0.
  - Increments by 1 on the clock edge leaving an instruction-boundary state (T5 for ALU ops, T6 for MUL/DIV). Illegal and HALT instructions are not counted.
  - Wraps 0xFFFFFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- ALU: reset 2 cycles, run=1, mem_ready tied 1, ir=32'h4A920000 (AND R5,R2,R4) -> states 0,1,2,3,4,5,6,1:
  - T3: gpr_out=16'h0004, y_in=1.
  - T4: gpr_out=16'h0010, z_in=1, alu_op=0000.
  - T5: z_low_out=1, gpr_in=16'h0020.
  - Next cycle is T0.
- Wait-states: mem_ready low for 3 cycles in T1 -> read=mdr_in=1 for exactly 4 cycles; ALU instruction completes in 9 cycles.
- MUL: ir opcode 01110, MULDIV_CYCLES=4 -> z_in=1 for exactly 4 cycles, alu_op=0100; then lo_in with z_low_out, then hi_in with z_high_out; gpr_in stays 0 throughout.
- Illegal, NUM_REGS=8: ir=32'h4A920000 (ra=5, rb=2, rc=4 all legal) runs normally; ir with rc=9 -> illegal_op pulses 1 cycle in T3, no gpr_out, next state T0.
- HALT and reset: ir=32'hD8000000 -> halted=1, stays in HALT for 20 cycles with run=1; reset=1 for 1 cycle -> IDLE, all outputs 0. Reset asserted mid-T4 of a MUL -> IDLE on the next edge, counter cleared.
- run gating / IR_SEQ_INSTR_COUNT_EN: drop run during T4 -> T5 then IDLE, no new T0; with macro defined, instr_count=3 after three completed instructions plus one illegal instruction.
